// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem reads, and a small
// instruction FIFO presented to the decoder with a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(BUF_DEPTH - 1);

  typedef enum logic {
    S_FETCH,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   issue_pc_q, issue_pc_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] buf_inst [BUF_DEPTH];
  logic [31:0] buf_pc   [BUF_DEPTH];

  logic push;
  logic pop;
  logic grant;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign imem_req  = rst_n && (state_q == S_FETCH)
                     && (count_q < DEPTH_C);
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = (state_q == S_WAIT) && imem_rvalid
                      && !drop_q && !redirect_valid;

  assign inst    = inst_valid ? buf_inst[rd_ptr_q] : '0;
  assign inst_pc = inst_valid ? buf_pc[rd_ptr_q] : '0;
  assign opcode  = inst[31:26];
  assign func    = inst[5:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    unique case (state_q)
      S_FETCH: begin
        if (grant) begin
          state_d    = S_WAIT;
          issue_pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_FETCH;
          drop_d  = 1'b0;
          if (push) pc_d = issue_pc_q + 32'd4;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    unique case (1'b1)
      push && !pop: count_d = count_q + CW'(1);
      pop && !push: count_d = count_q - CW'(1);
      default:      count_d = count_q;
    endcase

    // Redirect wins; a response already owed by memory must be swallowed
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (grant || (state_q == S_WAIT && !imem_rvalid))
        drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      issue_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      buf_inst[wr_ptr_q] <= imem_rdata;
      buf_pc[wr_ptr_q]   <= issue_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model plus reference queue of
// expected {pc, word} entries checked at the decoder side every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic [5:0]  func;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .opcode(opcode),
    .func(func)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        q[$];
  logic [31:0] popped[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_out;
  logic        m_drop;
  int          m_wait;
  int          lat;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2408_0005;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc   = RESET_PC;
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_wait = 0;
  endtask

  task automatic tick();
    logic        exp_req, granted, redir, pop, delivered;
    logic [31:0] ga, rpc;
    ent_t        e;
    delivered   = m_out && (m_wait == 0);
    imem_rvalid = rst_n && delivered;
    imem_rdata  = delivered ? mem_word(m_addr) : 32'hDEAD_BEEF;
    exp_req     = rst_n && !m_out && (q.size() < DEPTH);
    #1;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      chk("inst", inst, e.word);
      chk("inst_pc", inst_pc, e.pc);
      chk("opcode", 32'(opcode), 32'(e.word[31:26]));
      chk("func", 32'(func), 32'(e.word[5:0]));
    end else begin
      chk("inst_empty", inst, 32'h0);
      chk("inst_pc_empty", inst_pc, 32'h0);
    end
    granted = exp_req && imem_gnt;
    ga      = m_pc;
    redir   = redirect_valid;
    rpc     = redirect_pc;
    pop     = (q.size() != 0) && inst_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (pop && !redir) begin
      e = q.pop_front();
      popped.push_back(e.pc);
    end
    if (delivered) begin
      m_out = 1'b0;
      if (!m_drop && !redir) begin
        q.push_back('{pc: m_addr, word: mem_word(m_addr)});
        m_pc = m_addr + 32'd4;
      end
      m_drop = 1'b0;
    end else if (m_out) begin
      m_wait--;
      if (redir) m_drop = 1'b1;
    end
    if (redir) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end
    if (granted) begin
      m_out  = 1'b1;
      m_addr = ga;
      m_drop = redir;
      m_wait = lat - 1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_in_wait(input string tag);
    int n = 0;
    while (!(m_out && m_wait > 0) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(m_out && m_wait > 0), 32'd1);
  endtask

  task automatic wait_pops(input string tag, input int k);
    int n = 0;
    while (popped.size() < k && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(popped.size() >= k), 32'd1);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    lat            = 1;
    @(posedge clk);
    #1;
    model_reset();
    run(2);

    rst_n      = 1'b1;
    imem_gnt   = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, RESET_PC);
    popped.delete();
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t2_valid", 32'(inst_valid), 32'd1);
    chk("t2_opcode", 32'(opcode), 32'(6'b001001));
    chk("t2_func", 32'(func), 32'(6'b000101));
    chk("t2_pc", inst_pc, 32'h0);
    wait_pops("t1_npop", 3);
    if (popped.size() >= 3) begin
      chk("t1_pc0", popped[0], 32'h0);
      chk("t1_pc1", popped[1], 32'h4);
      chk("t1_pc2", popped[2], 32'h8);
    end

    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    inst_ready = 1'b0;
    run(8);
    chk("t3_req_off", 32'(imem_req), 32'd0);
    chk("t3_valid", 32'(inst_valid), 32'd1);
    chk("t3_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t3_req_on", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h8);

    inst_ready = 1'b1;
    lat        = 3;
    wait_in_wait("t4_wait");
    redirect(32'h0000_0103);
    popped.delete();
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("t4_addr", imem_addr, 32'h100);
    wait_pops("t4_npop", 1);
    if (popped.size() >= 1) chk("t4_pc", popped[0], 32'h100);

    imem_gnt = 1'b0;
    run(6);
    redirect(32'h0000_0302);
    chk("tr_req", 32'(imem_req), 32'd1);
    chk("tr_addr", imem_addr, 32'h300);
    imem_gnt = 1'b1;

    lat        = 1;
    inst_ready = 1'b0;
    run(8);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    redirect(32'h0000_0200);
    chk("t5_valid", 32'(inst_valid), 32'd0);
    chk("t5_req", 32'(imem_req), 32'd0);
    inst_ready = 1'b1;
    popped.delete();
    wait_pops("t5_npop", 1);
    if (popped.size() >= 1) chk("t5_pc", popped[0], 32'h200);

    redirect(32'hFFFF_FFFC);
    popped.delete();
    wait_pops("t6_npop", 2);
    if (popped.size() >= 2) begin
      chk("t6_pc0", popped[0], 32'hFFFF_FFFC);
      chk("t6_pc1", popped[1], 32'h0000_0000);
    end
    lat = 3;
    wait_in_wait("t6_wait");
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr, RESET_PC);
    run(6);

    for (int i = 0; i < 400; i++) begin
      imem_gnt       = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom();
      tick();
    end
    redirect_valid = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
